// File: rtl/gbt_frameclk_strobe_gen_if.sv
// Frame-clock strobe generator bus: frame-boundary pulse in; strobes, lock status and
// debug counters out.
interface gbt_frameclk_strobe_gen_if #(
  parameter int NUM_OUT = 2
);
  logic               align_i;
  logic [NUM_OUT-1:0] strobe_o;
  logic               locked;
  logic [7:0]         phase_o;
  logic [7:0]         loss_cnt_o;

  modport master (
    input  align_i,
    output strobe_o, locked, phase_o, loss_cnt_o
  );

  modport slave (
    output align_i,
    input  strobe_o, locked, phase_o, loss_cnt_o
  );
endinterface

// File: rtl/gbt_frameclk_strobe_gen.sv
// Frame-rate clock-enable strobes derived from the word clock, phase-aligned to a frame
// pulse, with a lock supervisor that tracks how well the pulse matches the phase counter.
module gbt_frameclk_strobe_gen #(
  parameter int                   DIV_RATIO   = 3,
  parameter int                   NUM_OUT     = 2,
  parameter logic [8*NUM_OUT-1:0] PHASE_OFS   = {8'd1, 8'd0},
  parameter int                   LOCK_COUNT  = 4,
  parameter int                   BAD_COUNT   = 2,
  parameter bit                   GATE_UNLOCK = 1'b1
) (
  input  logic                     refclk,
  input  logic                     rst,
  gbt_frameclk_strobe_gen_if.master bus
);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  localparam logic [7:0] CNT_MAX   = 8'(DIV_RATIO - 1);
  localparam logic [3:0] GOOD_LAST = 4'(LOCK_COUNT - 1);
  localparam logic [3:0] BAD_LAST  = 4'(BAD_COUNT - 1);

  state_t             state;
  state_t             state_nxt;
  logic [7:0]         cnt;
  logic [3:0]         good;
  logic [3:0]         bad;
  logic [3:0]         good_nxt;
  logic [3:0]         bad_nxt;
  logic [7:0]         loss_cnt;
  logic [NUM_OUT-1:0] strobe;
  logic [NUM_OUT-1:0] strobe_nxt;
  logic               locked_q;
  logic               locked_next;
  logic               armed;
  logic               align_v;
  logic               align_good;
  logic               realign;
  logic               loss_evt;

  // armed stays low for the first edge after reset release, so an align there is dropped
  assign align_v     = bus.align_i & armed;
  assign align_good  = (cnt == 8'd0);
  assign locked_next = (state_nxt == LOCKED);

  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    bad_nxt   = bad;
    realign   = 1'b0;
    loss_evt  = 1'b0;
    if (align_v) begin
      case (state)
        UNLOCKED: begin
          realign   = 1'b1;
          good_nxt  = 4'd0;
          state_nxt = ACQUIRE;
        end
        ACQUIRE: begin
          if (align_good) begin
            if (good == GOOD_LAST) begin
              state_nxt = LOCKED;
              bad_nxt   = 4'd0;
            end else begin
              good_nxt = good + 4'd1;
            end
          end else begin
            realign  = 1'b1;
            good_nxt = 4'd0;
          end
        end
        LOCKED: begin
          if (align_good) begin
            bad_nxt = 4'd0;
          end else if (bad == BAD_LAST) begin
            realign   = 1'b1;
            good_nxt  = 4'd0;
            bad_nxt   = 4'd0;
            state_nxt = ACQUIRE;
            loss_evt  = 1'b1;
          end else begin
            bad_nxt = bad + 4'd1;
          end
        end
        default: state_nxt = UNLOCKED;
      endcase
    end
  end

  // Strobes look at the pre-realign phase and the post-transition lock state
  always_comb begin
    strobe_nxt = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      strobe_nxt[i] = (cnt == PHASE_OFS[8*i +: 8]) & (!GATE_UNLOCK | locked_next);
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state    <= UNLOCKED;
      cnt      <= 8'd0;
      good     <= 4'd0;
      bad      <= 4'd0;
      loss_cnt <= 8'd0;
      strobe   <= '0;
      locked_q <= 1'b0;
      armed    <= 1'b0;
    end else begin
      armed    <= 1'b1;
      state    <= state_nxt;
      good     <= good_nxt;
      bad      <= bad_nxt;
      locked_q <= locked_next;
      strobe   <= strobe_nxt;
      if (loss_evt && (loss_cnt != 8'hFF)) begin
        loss_cnt <= loss_cnt + 8'd1;
      end
      // a realign overrides the natural wrap: the align cycle becomes phase 0
      if (realign) begin
        cnt <= 8'd1;
      end else if (cnt == CNT_MAX) begin
        cnt <= 8'd0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  assign bus.strobe_o   = strobe;
  assign bus.locked     = locked_q;
  assign bus.phase_o    = cnt;
  assign bus.loss_cnt_o = loss_cnt;

endmodule

// File: tb/tb_gbt_frameclk_strobe_gen.sv
// Bench for the frame-clock strobe generator: three configurations run side by side
// against a frame-origin reference model.
module tb_gbt_frameclk_strobe_gen;

  logic refclk = 1'b0;
  logic rst    = 1'b1;
  always #5 refclk = ~refclk;

  gbt_frameclk_strobe_gen_if #(.NUM_OUT(2)) if0 ();
  gbt_frameclk_strobe_gen_if #(.NUM_OUT(2)) if1 ();
  gbt_frameclk_strobe_gen_if #(.NUM_OUT(3)) if2 ();

  gbt_frameclk_strobe_gen u0 (.refclk(refclk), .rst(rst), .bus(if0));

  gbt_frameclk_strobe_gen #(.GATE_UNLOCK(1'b0)) u1 (.refclk(refclk), .rst(rst), .bus(if1));

  gbt_frameclk_strobe_gen #(
    .DIV_RATIO(8), .NUM_OUT(3), .PHASE_OFS({8'd7, 8'd4, 8'd0})
  ) u2 (.refclk(refclk), .rst(rst), .bus(if2));

  logic [2:0] st_o [3];
  logic       lk_o [3];
  logic [7:0] ph_o [3];
  logic [7:0] ls_o [3];

  assign st_o[0] = {1'b0, if0.strobe_o};
  assign st_o[1] = {1'b0, if1.strobe_o};
  assign st_o[2] = if2.strobe_o;
  assign lk_o[0] = if0.locked;
  assign lk_o[1] = if1.locked;
  assign lk_o[2] = if2.locked;
  assign ph_o[0] = if0.phase_o;
  assign ph_o[1] = if1.phase_o;
  assign ph_o[2] = if2.phase_o;
  assign ls_o[0] = if0.loss_cnt_o;
  assign ls_o[1] = if1.loss_cnt_o;
  assign ls_o[2] = if2.loss_cnt_o;

  // configuration of each instance, as seen by the model
  localparam int LOCK_N = 4;
  localparam int BAD_N  = 2;
  int div_k  [3]    = '{3, 3, 8};
  int nout_k [3]    = '{2, 2, 3};
  bit gate_k [3]    = '{1'b1, 1'b0, 1'b1};
  int ofs_k  [3][3] = '{'{0, 1, 0}, '{0, 1, 0}, '{0, 4, 7}};

  // model state: phase is (t - org) mod DIV; mode 0 unlocked, 1 acquiring, 2 locked
  int         t;
  int         org   [3];
  int         mode  [3];
  int         ngood [3];
  int         nbad  [3];
  int         loss  [3];
  bit         rdy   [3];
  logic [2:0] exp_st[3];
  bit         exp_lk[3];
  bit         al    [3];

  int n_chk = 0;
  int n_bad = 0;
  int seg;
  int dir0[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  function automatic int pmod(input int a, input int m);
    int r;
    r = a % m;
    return (r < 0) ? r + m : r;
  endfunction

  task automatic model_reset();
    t = 0;
    for (int k = 0; k < 3; k++) begin
      org[k] = 0; mode[k] = 0; ngood[k] = 0; nbad[k] = 0; loss[k] = 0;
      rdy[k] = 1'b0; exp_st[k] = '0; exp_lk[k] = 1'b0;
    end
  endtask

  task automatic step(input int k);
    int ph;
    bit a;
    bit re;
    int nx;
    ph = pmod(t - org[k], div_k[k]);
    a  = al[k] && rdy[k];
    re = 1'b0;
    nx = mode[k];
    if (a) begin
      if (mode[k] == 0) begin
        re = 1'b1; ngood[k] = 0; nx = 1;
      end else if (mode[k] == 1) begin
        if (ph == 0) begin
          ngood[k]++;
          if (ngood[k] == LOCK_N) begin nx = 2; nbad[k] = 0; end
        end else begin
          re = 1'b1; ngood[k] = 0;
        end
      end else begin
        if (ph == 0) nbad[k] = 0;
        else begin
          nbad[k]++;
          if (nbad[k] == BAD_N) begin
            re = 1'b1; ngood[k] = 0; nbad[k] = 0; nx = 1;
            if (loss[k] < 255) loss[k]++;
          end
        end
      end
    end
    exp_st[k] = '0;
    for (int i = 0; i < nout_k[k]; i++)
      exp_st[k][i] = (ph == ofs_k[k][i]) && (!gate_k[k] || nx == 2);
    exp_lk[k] = (nx == 2);
    if (re) org[k] = t;
    mode[k] = nx;
    rdy[k]  = 1'b1;
  endtask

  task automatic do_checks();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d_phase", k), 32'(ph_o[k]), 32'(pmod(t - org[k], div_k[k])));
      chk($sformatf("u%0d_strobe", k), 32'(st_o[k]), 32'(exp_st[k]));
      chk($sformatf("u%0d_locked", k), 32'(lk_o[k]), 32'(exp_lk[k]));
      chk($sformatf("u%0d_loss", k), 32'(ls_o[k]), 32'(loss[k]));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_u%0d_strobe", tag, k), 32'(st_o[k]), 32'd0);
      chk($sformatf("%s_u%0d_locked", tag, k), 32'(lk_o[k]), 32'd0);
      chk($sformatf("%s_u%0d_phase", tag, k), 32'(ph_o[k]), 32'd0);
      chk($sformatf("%s_u%0d_loss", tag, k), 32'(ls_o[k]), 32'd0);
    end
  endtask

  function automatic bit rnd_align(input int k);
    if (pmod(t - org[k], div_k[k]) == 0) return ($urandom % 4) != 0;
    return ($urandom % 12) == 0;
  endfunction

  task automatic drive();
    for (int k = 0; k < 3; k++) al[k] = 1'b0;
    if (seg == 0) begin
      foreach (dir0[i]) if (dir0[i] == t) al[0] = 1'b1;
      al[2] = (t >= 5) && ((t - 5) % 8 == 0);
    end else if (seg == 3) begin
      al[0] = (pmod(t - org[0], div_k[0]) == 0);
      al[1] = rnd_align(1);
      al[2] = rnd_align(2);
    end else begin
      for (int k = 0; k < 3; k++) al[k] = (seg == 2 && t == 0) ? 1'b1 : rnd_align(k);
    end
    if0.align_i = al[0];
    if1.align_i = al[1];
    if2.align_i = al[2];
  endtask

  task automatic advance();
    for (int k = 0; k < 3; k++) step(k);
    t++;
  endtask

  task automatic directed_checks();
    if (t == 1)  chk("gate0_strobe_first", 32'(st_o[1]), 32'd1);
    if (t == 2)  chk("gate0_strobe_second", 32'(st_o[1]), 32'd2);
    if (t == 22) chk("lock_not_yet", 32'(lk_o[0]), 32'd0);
    if (t == 23) chk("lock_rise", 32'(lk_o[0]), 32'd1);
    if (t == 23) chk("lock_strobe0", 32'(st_o[0]), 32'd1);
    if (t == 24) chk("lock_strobe1", 32'(st_o[0]), 32'd2);
    if (t == 42) chk("shift1_locked", 32'(lk_o[0]), 32'd1);
    if (t == 42) chk("shift1_no_realign", 32'(ph_o[0]), 32'd2);
    if (t == 54) chk("shift2_unlock", 32'(lk_o[0]), 32'd0);
    if (t == 54) chk("shift2_loss", 32'(ls_o[0]), 32'd1);
    if (t == 54) chk("shift2_realign", 32'(ph_o[0]), 32'd1);
    if (t == 66) chk("relock", 32'(lk_o[0]), 32'd1);
    if (t == 70) chk("gate0_never_locked", 32'(lk_o[1]), 32'd0);
    if (t == 38) chk("div8_strobe_ph0", 32'(st_o[2]), 32'd1);
    if (t == 42) chk("div8_strobe_ph4", 32'(st_o[2]), 32'd2);
    if (t == 45) chk("div8_strobe_ph7", 32'(st_o[2]), 32'd4);
  endtask

  task automatic run_cycle();
    @(negedge refclk);
    do_checks();
    if (seg == 0) directed_checks();
    drive();
    @(posedge refclk);
    advance();
  endtask

  initial begin
    bit found;
    for (int v = 10; v <= 37; v += 3) dir0.push_back(v);
    dir0.push_back(41); dir0.push_back(43); dir0.push_back(46);
    dir0.push_back(50); dir0.push_back(53);
    for (int v = 56; v <= 68; v += 3) dir0.push_back(v);

    if0.align_i = 1'b0; if1.align_i = 1'b0; if2.align_i = 1'b0;
    for (int k = 0; k < 3; k++) al[k] = 1'b0;
    model_reset();
    repeat (3) @(posedge refclk);
    @(negedge refclk);
    check_zero("reset");
    @(posedge refclk);
    #2 rst = 1'b0;

    seg = 0;
    for (int c = 0; c < 80; c++) run_cycle();
    seg = 1;
    for (int c = 0; c < 300; c++) run_cycle();
    seg = 3;
    for (int c = 0; c < 30; c++) run_cycle();

    // stop on a cycle where u0 is locked and its phase-0 strobe is due next edge
    found = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge refclk);
      do_checks();
      if (mode[0] == 2 && pmod(t - org[0], div_k[0]) == 0) begin
        found = 1'b1;
        break;
      end
      drive();
      @(posedge refclk);
      advance();
    end
    chk("rst_setup_locked", 32'(found), 32'd1);

    if0.align_i = 1'b0; if1.align_i = 1'b0; if2.align_i = 1'b0;
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    model_reset();
    for (int k = 0; k < 3; k++) al[k] = 1'b0;
    @(posedge refclk);
    #1 check_zero("rst_held");
    #1 rst = 1'b0;

    seg = 2;
    for (int c = 0; c < 150; c++) run_cycle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
